// File: rtl/mul_16bit_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding
// and iteration constants.
package mul_16bit_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   localparam int MUL_ITERS = 16;
   localparam int MUL_CNT_W = 4;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups; exports
// group generate/propagate so the caller can form the carry-out.
module adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] sum,
   output logic        g_out,
   output logic        p_out
);

   logic [15:0] g;
   logic [15:0] p;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [3:0]  gc;

   // Sum bits of one 4-bit group given its carry-in, carries fully expanded.
   function automatic logic [3:0] cla4_sum(input logic [3:0] gi,
                                           input logic [3:0] pi,
                                           input logic       ci);
      logic c1;
      logic c2;
      logic c3;
      c1 = gi[0] | (pi[0] & ci);
      c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
      c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                 | (pi[2] & pi[1] & pi[0] & ci);
      return pi ^ {c3, c2, c1, ci};
   endfunction

   assign g = a & b;
   assign p = a ^ b;

   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_grp
         assign gg[k] = g[4*k+3]
                      | (p[4*k+3] & g[4*k+2])
                      | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                      | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         assign gp[k] = &p[4*k+3 -: 4];
         assign sum[4*k+3 -: 4] = cla4_sum(g[4*k+3 -: 4], p[4*k+3 -: 4], gc[k]);
      end
   endgenerate

   // Second-level lookahead: group carries straight from c_in.
   assign gc[0] = c_in;
   assign gc[1] = gg[0] | (gp[0] & c_in);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                        | (gp[2] & gp[1] & gp[0] & c_in);

   assign g_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                        | (gp[3] & gp[2] & gp[1] & gg[0]);
   assign p_out = &gp;

endmodule

// File: rtl/mul_16bit_seq.sv
// Sequential 16x16 unsigned shift-add multiplier, one partial product per cycle.
// Optional MUL_ZERO_SKIP_EN: a zero operand goes straight to DONE with product 0.
module mul_16bit_seq
   import mul_16bit_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; in_ready is high only in IDLE, out_valid only in DONE, and
   // operands/product must stay stable while their valid is high and unaccepted.

   localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(MUL_ITERS - 1);

   mul_state_e              state_q, state_d;
   logic [2*WIDTH-1:0]      acc_q, acc_d;
   logic [2*WIDTH-1:0]      res_q, res_d;
   logic [WIDTH-1:0]        mcand_q, mcand_d;
   logic [MUL_CNT_W-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0]        addend;
   logic [WIDTH-1:0]        add_sum;
   logic                    add_g;
   logic                    add_p;
   logic                    add_cin;
   logic                    add_cout;
   logic [2*WIDTH-1:0]      acc_shift;

   assign add_cin = 1'b0;
   assign addend  = acc_q[0] ? mcand_q : '0;

   adder_16bit u_adder (
      .a     (acc_q[2*WIDTH-1:WIDTH]),
      .b     (addend),
      .c_in  (add_cin),
      .sum   (add_sum),
      .g_out (add_g),
      .p_out (add_p)
   );

   assign add_cout  = add_g | (add_p & add_cin);
   // 33-bit {cout,sum,low} shifted right by one into the 32-bit accumulator.
   assign acc_shift = {add_cout, add_sum, acc_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         res_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      res_d     = res_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mcand_d = in1;
               cnt_d   = '0;
               acc_d   = {{WIDTH{1'b0}}, in2};
               state_d = BUSY;
`ifdef MUL_ZERO_SKIP_EN
               if ((in1 == '0) || (in2 == '0)) begin
                  acc_d   = '0;
                  res_d   = '0;
                  state_d = DONE;
               end
`endif
            end
         end
         BUSY: begin
            acc_d = acc_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               res_d   = acc_shift;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // res_q only changes on entry to DONE, so product holds the last result
   // through the next operation instead of exposing the working accumulator.
   assign product   = res_q;
   assign dbg_state = state_q;

endmodule

// File: doc/mul_16bit_seq.md
MUL_16BIT_SEQ -- requirements
Module: mul_16bit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width; only 16 is supported, matching the 16-bit CLA adder.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports in1 and in2, input, 16 bits each: multiplicand and multiplier, unsigned.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the product is available.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-009 The block SHALL have port product, output, 32 bits: the unsigned product in1*in2.

Function
REQ-010 The block SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-011 In IDLE the block SHALL hold in_ready=1 and out_valid=0.
REQ-012 When in_valid&&in_ready is high, the block SHALL latch in1 as the multiplicand, load acc={16'h0,in2}, clear the iteration counter, and go to BUSY.
REQ-013 In BUSY the block SHALL perform one iteration per cycle, for exactly 16 cycles (counter 0..15).
REQ-014 Each BUSY iteration SHALL compute {cout,sum} = acc[31:16] + multiplicand when acc[0]=1, else acc[31:16] + 0, with c_in=0.
REQ-015 In the same BUSY iteration, acc SHALL become {cout,sum,acc[15:1]} (a 33-to-32 right shift).
REQ-016 cout SHALL be derived from the adder group outputs as G | (P & c_in); with c_in=0 this reduces to G.
REQ-017 After iteration 15 the block SHALL go to DONE.
REQ-018 In DONE the block SHALL hold out_valid=1 and product=acc, stable, until out_ready=1; on that edge it SHALL go to IDLE.
REQ-019 Latency SHALL be: acceptance at edge N, out_valid high from edge N+17.
REQ-020 The block SHALL accept a new operand pair no earlier than the cycle after the out_valid&&out_ready handshake (no overlap).
REQ-021 in_ready SHALL be 0 in BUSY and DONE; in_valid and operand changes in those states SHALL be ignored.
REQ-022 product SHALL equal the last result, or 0 after reset, while out_valid=0; consumers SHALL sample it only when out_valid=1.
REQ-023 No overflow is possible: product SHALL be exact for all 2^32 operand pairs.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, acc=0, multiplicand=0 and counter=0, giving in_ready=1, out_valid=0 and product=0.
REQ-025 A reset asserted during BUSY or DONE SHALL abort the operation with no output handshake; the first accept after release SHALL behave as from cold reset.

Configuration
REQ-026 The feature macro SHALL be MUL_ZERO_SKIP_EN.
REQ-027 With MUL_ZERO_SKIP_EN defined, an accepted pair with in1==0 or in2==0 SHALL bypass BUSY: acc=0, state goes directly to DONE, and out_valid is high from edge N+1.
REQ-028 Without MUL_ZERO_SKIP_EN, all operands SHALL take the full 16 BUSY cycles.
REQ-029 Results SHALL be identical with and without MUL_ZERO_SKIP_EN.

Structure
REQ-030 The shared CPU package SHALL hold the FSM state enum (IDLE/BUSY/DONE, 2 bits), the MUL_ITERS=16 constant and the MUL_CNT_W=4 constant.
REQ-031 The block SHALL instantiate exactly one sub-module, the existing adder_16bit, for the partial-sum add.
REQ-032 The FSM, counter, accumulator shift and handshake SHALL be implemented locally in mul_16bit_seq.

Verification
REQ-033 Basic product: in1=3, in2=5 accepted -> product=32'h0000000F with out_valid high exactly 17 cycles after acceptance.
REQ-034 Carry path: in1=16'hFFFF, in2=16'hFFFF -> product=32'hFFFE0001.
REQ-035 Backpressure: in1=16'h1234, in2=16'h0100, out_ready=0 for 5 cycles after out_valid -> product=32'h00123400 held stable, in_ready stays 0 throughout, and the state returns to IDLE on the first cycle with out_ready=1.
REQ-036 Zero operand: in1=0, in2=16'hABCD -> product=0, after 1 cycle with MUL_ZERO_SKIP_EN defined and after 17 cycles without it.
REQ-037 Reset mid-operation: rst_n pulsed low at BUSY iteration 7 -> in_ready=1, out_valid=0 and product=0 immediately; a following 7*9 -> product=63.
REQ-038 Ignored input: in_valid held high with changing operands during BUSY -> only the first pair's product is output, and exactly one out_valid handshake occurs.
